mc_control: RTL

Multi-cycle main controller for the MIPS core. Sequences the shared 32-bit ALU, instruction/data memory port, register file and PC through fetch, decode, execute, memory and writeback states, one instruction at a time. It drives the ALU's 6-bit function code and operand selects, and it traps arithmetic overflow and reserved opcodes to an exception vector.

---
 rtl/mc_control.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_control.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// one instruction at a time and traps overflow and reserved opcodes to the exception vector.
`timescale 1ns/1ps
module mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    input  logic       overflow_exception,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [5:0] alu_funct,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       epc_write,
    output logic [1:0] exc_cause,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_I_EXEC   = 4'd11,
        S_I_WB     = 4'd12,
        S_EXC      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_RI   = 2'b10;

    state_t     state_q, state_d;
    logic [1:0] exc_cause_q, exc_cause_d;

    // State and exception-cause registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            exc_cause_q <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    assign state     = state_q;
    assign exc_cause = exc_cause_q;

    // Next-state and per-state datapath control decode
    always_comb begin
        state_d       = state_q;
        exc_cause_d   = exc_cause_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_funct     = 6'b000000;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        epc_write     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_funct = FN_ADDU;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_funct = FN_ADDU;
                case (opcode)
                    OP_RTYPE:      state_d = S_R_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_I_EXEC;
                    default: begin
                        state_d     = S_EXC;
                        exc_cause_d = EXC_RI;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_funct = FN_ADDU;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_funct = funct;
                if (funct == FN_JR) begin
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else if ((funct == FN_ADD || funct == FN_SUB) && overflow_exception) begin
                    state_d     = S_EXC;
                    exc_cause_d = EXC_OVF;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_funct     = FN_SUBU;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = opcode[0];
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_funct = FN_ADD;
                if (overflow_exception) begin
                    state_d     = S_EXC;
                    exc_cause_d = EXC_OVF;
                end else begin
                    state_d = S_I_WB;
                end
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXC: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_source = 2'b11;
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // zero_flag is consumed by the PC-update logic, not by the sequencer
    logic unused_zero;
    assign unused_zero = zero_flag;

endmodule
